branch_resolve: RTL

Downstream consumer of the 3-bit Z/V/N flag register. It evaluates the condition code of B (PC-relative) and BR (register) instructions against the committed flags and computes the branch target. It issues a one-cycle fetch redirect plus a multi-cycle flush of younger instructions. It stalls the branch while an older flag-setting ALU op has not yet written the flag register.

---
 rtl/branch_resolve_pkg.sv | 25 ++
 rtl/branch_resolve_cond_eval.sv | 27 ++
 rtl/branch_resolve.sv | 136 +++++++++++++
 3 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared constants for branch resolution: opcodes, condition encodings, FSM states.
package branch_resolve_pkg;

  localparam int BR_PC_W = 16;

  localparam logic [3:0] OP_B  = 4'b1100;
  localparam logic [3:0] OP_BR = 4'b1101;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FLAGS = 2'd1,
    S_REDIRECT   = 2'd2,
    S_FLUSH      = 2'd3
  } state_e;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Combinational condition-code evaluation against the Z/V/N flags.
module branch_cond_eval
  import branch_resolve_pkg::*;
(
  input  logic [2:0] i_ccc,
  input  logic       i_z,
  input  logic       i_v,
  input  logic       i_n,
  output logic       o_take
);

  always_comb begin
    o_take = 1'b0;
    case (i_ccc)
      CC_NE:     o_take = ~i_z;
      CC_EQ:     o_take = i_z;
      CC_GT:     o_take = ~i_z & ~i_n;
      CC_LT:     o_take = i_n;
      CC_GTE:    o_take = i_z | (~i_z & ~i_n);
      CC_LTE:    o_take = i_n | i_z;
      CC_OVFL:   o_take = i_v;
      CC_UNCOND: o_take = 1'b1;
      default:   o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves B/BR branches: stalls on pending flag writes, then redirects fetch and flushes.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = BR_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [3:0]      opCode,
  input  logic [2:0]      ccc,
  input  logic [8:0]      imm9,
  input  logic [PC_W-1:0] pc_plus2,
  input  logic [PC_W-1:0] rs_data,
  input  logic            Zf,
  input  logic            Vf,
  input  logic            Nf,
  input  logic            flag_wr_pending,
  output logic            stall,
  output logic            redirect,
  output logic [PC_W-1:0] target,
  output logic            flush,
  output logic            taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     br_taken_cnt,
  output logic [15:0]     br_nt_cnt
`endif
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e          r_state;
  logic [2:0]      r_cnt;
  logic [PC_W-1:0] r_target;
  logic            r_redirect;
  logic            r_flush;
  logic            r_taken;

  logic            w_is_br;
  logic            w_wait;
  logic            w_resolve;
  logic            w_cond;
  logic            w_go;
  logic [PC_W-1:0] w_sext;
  logic [PC_W-1:0] w_target;

  assign w_is_br = valid_in & ((opCode == OP_B) | (opCode == OP_BR));
  assign w_wait  = w_is_br & flag_wr_pending & (ccc != CC_UNCOND);
  // Only IDLE/WAIT_FLAGS look at decode; REDIRECT/FLUSH cycles carry wrong-path instructions.
  assign w_resolve = ((r_state == S_IDLE) | (r_state == S_WAIT_FLAGS)) & w_is_br & ~w_wait;
  assign w_go      = w_resolve & w_cond;

  assign w_sext   = {{(PC_W-9){imm9[8]}}, imm9};
  assign w_target = (opCode == OP_BR) ? rs_data : pc_plus2 + {w_sext[PC_W-2:0], 1'b0};

  branch_cond_eval u_cond (
    .i_ccc  (ccc),
    .i_z    (Zf),
    .i_v    (Vf),
    .i_n    (Nf),
    .o_take (w_cond)
  );

  // Stall is combinational so decode holds in the same cycle; reset forces it low at once.
  assign stall = rst & (((r_state == S_IDLE) & w_wait) |
                        ((r_state == S_WAIT_FLAGS) & flag_wr_pending));

  assign redirect = r_redirect;
  assign taken    = r_taken;
  assign flush    = r_flush;
  assign target   = r_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_target   <= '0;
      r_redirect <= 1'b0;
      r_taken    <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      r_taken    <= 1'b0;
      case (r_state)
        S_IDLE, S_WAIT_FLAGS: begin
          if (w_go) begin
            r_state    <= S_REDIRECT;
            r_target   <= w_target;
            r_redirect <= 1'b1;
            r_taken    <= 1'b1;
            r_flush    <= 1'b1;
            r_cnt      <= FLUSH_LOAD;
          end else if ((r_state == S_IDLE) ? w_wait : flag_wr_pending) begin
            r_state <= S_WAIT_FLAGS;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          if (r_cnt == 3'd0) begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
          end else begin
            r_state <= S_FLUSH;
            r_cnt   <= r_cnt - 3'd1;
          end
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] r_tk_cnt;
  logic [15:0] r_nt_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tk_cnt <= 16'd0;
      r_nt_cnt <= 16'd0;
    end else if (w_resolve) begin
      if (w_cond) begin
        if (r_tk_cnt != 16'hFFFF) r_tk_cnt <= r_tk_cnt + 16'd1;
      end else begin
        if (r_nt_cnt != 16'hFFFF) r_nt_cnt <= r_nt_cnt + 16'd1;
      end
    end
  end

  assign br_taken_cnt = r_tk_cnt;
  assign br_nt_cnt    = r_nt_cnt;
`endif

endmodule
